game_ctrl: RTL
==============

# game_ctrl

Parametrised game-flow controller for the VGA arcade designs. It sits beside the VGA timing generator and the sprite/enemy instances. It turns vblank into gated per-frame move pulses, counts destroyed enemies into a saturating score, and tracks lives and levels. It also runs the IDLE/PLAY/PAUSE/RESPAWN/CLEAR/WON/LOST state machine that drives death/win indication and the enemy and player re-arm pulses.

## Interface
- N_ENEMIES, 16: width of enemy_broken; a level is cleared when all N_ENEMIES bits are set.
- SCORE_W, 8: score width.
- LIVES, 3: lives at game start (≥1).
- LEVELS, 4: number of levels; clearing level LEVELS-1 wins.
- BASE_DIV, 4: frames per move at level 0; divisor = max(1, BASE_DIV-level).
- RESPAWN_FRAMES, 60: frames with movement frozen after a player hit.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset; asynchronous, active-high.
- pixpulse  in  1  pixel-rate enable (1 in 4 clk).
- vblank  in  1  vertical blank from timing generator.
- start  in  1  run switch, level-sensitive.
- player_hit  in  1  player sprite destroyed (level).
- enemy_broken  in  N_ENEMIES  per-enemy destroyed flags.
- move  out  1  one-clk movement strobe.
- level_rst  out  1  one-clk pulse re-arming all enemies.
- player_rst  out  1  one-clk pulse re-arming the player sprite.
- score  out  SCORE_W  total score.
- lives  out  $clog2(LIVES+1)  remaining lives.
- level  out  $clog2(LEVELS) (min 1)  current level.
- state  out  3  IDLE=0, PLAY=1, PAUSE=2, RESPAWN=3, CLEAR=4, WON=5, LOST=6.
- death  out  1  high while state==LOST.
- won  out  1  high while state==WON.

## Operation
- Frame tick: vblank_d1 updates on pixpulse. frame_tick = pixpulse & vblank & ~vblank_d1, one clk per frame.
- Frame divider fdiv counts frame_ticks in PLAY only. When fdiv == divisor-1 it produces move and wraps to 0. fdiv clears on any state change.
- Popcount: cnt = number of set bits in enemy_broken. It is recomputed combinationally and registered each clk.
- Score = bank + cnt_reg, saturating at 2^SCORE_W-1. On entry to CLEAR, bank += N_ENEMIES, also saturating.
- hit_edge = player_hit rising edge (registered previous value).
- IDLE: score, bank, level and fdiv are 0; lives = LIVES. When start is high, go to PLAY and pulse level_rst and player_rst.
- PLAY transitions, evaluated in this priority:
  - cnt_reg == N_ENEMIES: go to WON if level == LEVELS-1, else CLEAR.
  - hit_edge: decrement lives. If lives was 1, go to LOST; otherwise go to RESPAWN and pulse player_rst.
  - start low: go to PAUSE.
- PAUSE: move is suppressed and other state is held. When start is high, return to PLAY.
- RESPAWN: count RESPAWN_FRAMES frame_ticks, then go to PLAY. start low does not pause during RESPAWN.
- CLEAR: increment level and pulse level_rst on entry. Wait for one frame_tick, then go to PLAY.
- WON/LOST: move is suppressed and score is held. When start is low, go to IDLE.
- A simultaneous clear and hit goes to CLEAR (or WON); the hit is discarded and lives are unchanged.
- hit_edge outside PLAY is ignored.

## Timing
- Reset values: state=IDLE, move=0, level_rst=0, player_rst=0, score=0, lives=LIVES, level=0, death=0, won=0. Internal counters and vblank_d1 are 0.
- An asynchronous reset mid-game returns every output to its reset value immediately. The first move after release needs start plus a vblank edge.
- move, level_rst and player_rst are registered. Each is high for exactly 1 clk, one clk after its cause.
- score lags enemy_broken by 2 clk (popcount register, then score register). state lags the cause by 1 clk.
- death and won are registered decodes of state, same cycle as state.
- At most one move per frame. move never coincides with state≠PLAY.

## Test plan
- Move divider: BASE_DIV=4, start=1, 12 vblank edges at level 0 → exactly 3 move pulses, each 1 clk wide, on every 4th frame; start=0 → state=2 and no moves.
- Scoring: set enemy_broken bits 0,3,7 → score=3 two clk later; all 16 set → state=4, level_rst pulse, level=1; clear inputs → score=16; after 1 frame, state=1.
- Lives: three player_hit rising edges separated by RESPAWN_FRAMES+1 frames → lives 2,1,0; states go RESPAWN, RESPAWN, LOST; death=1; start=0 → IDLE, lives=3, score=0.
- Simultaneous: all enemies broken in the same clk as player_hit rises → state=4, lives unchanged.
- Win/saturation: SCORE_W=5, LEVELS=2, clear both levels → state=5, won=1, score saturates at 31.
- Async reset asserted mid-RESPAWN → all outputs at reset values within the same clk; no stray move.

Source files
------------

// File: rtl/game_ctrl.sv
// Game-flow controller: frame-gated move strobes, saturating score, lives/levels,
// and the IDLE/PLAY/PAUSE/RESPAWN/CLEAR/WON/LOST sequencing with re-arm pulses.
module game_ctrl #(
  parameter int N_ENEMIES      = 16,
  parameter int SCORE_W        = 8,
  parameter int LIVES          = 3,
  parameter int LEVELS         = 4,
  parameter int BASE_DIV       = 4,
  parameter int RESPAWN_FRAMES = 60,
  localparam int LIVES_W       = $clog2(LIVES + 1),
  localparam int LEVEL_W       = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pixpulse,
  input  logic                 vblank,
  input  logic                 start,
  input  logic                 player_hit,
  input  logic [N_ENEMIES-1:0] enemy_broken,
  output logic                 move,
  output logic                 level_rst,
  output logic                 player_rst,
  output logic [SCORE_W-1:0]   score,
  output logic [LIVES_W-1:0]   lives,
  output logic [LEVEL_W-1:0]   level,
  output logic [2:0]           state,
  output logic                 death,
  output logic                 won
);

  localparam int CNT_W = $clog2(N_ENEMIES + 1);
  localparam int DIV_W = $clog2(BASE_DIV + 1);
  localparam int RSP_W = $clog2(RESPAWN_FRAMES + 1);
  localparam int SUM_W = ((SCORE_W > CNT_W) ? SCORE_W : CNT_W) + 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLAY    = 3'd1,
    S_PAUSE   = 3'd2,
    S_RESPAWN = 3'd3,
    S_CLEAR   = 3'd4,
    S_WON     = 3'd5,
    S_LOST    = 3'd6
  } state_t;

  state_t               state_r, state_nxt;
  logic                 vblank_d1, frame_tick;
  logic                 hit_q, hit_edge_r;
  logic [CNT_W-1:0]     cnt_next, cnt_r;
  logic [DIV_W-1:0]     fdiv_r, div_m1;
  logic [RSP_W-1:0]     rsp_r;
  logic [SCORE_W-1:0]   bank_r, bank_sat, score_sat;
  logic [SUM_W-1:0]     score_sum, bank_sum;
  logic [LIVES_W-1:0]   lives_r;
  logic [LEVEL_W-1:0]   level_r;
  logic                 move_nxt, lrst_nxt, prst_nxt, dec_life;

  assign frame_tick = pixpulse & vblank & ~vblank_d1;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < N_ENEMIES; i++) cnt_next = cnt_next + CNT_W'(enemy_broken[i]);
  end

  // divisor-1 = max(0, BASE_DIV-1-level)
  always_comb begin
    div_m1 = '0;
    if (int'(level_r) < BASE_DIV - 1) div_m1 = DIV_W'(BASE_DIV - 1 - int'(level_r));
  end

  always_comb begin
    score_sum = SUM_W'(bank_r) + SUM_W'(cnt_r);
    score_sat = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
    bank_sum  = SUM_W'(bank_r) + SUM_W'(N_ENEMIES);
    bank_sat  = (bank_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : bank_sum[SCORE_W-1:0];
  end

  // hit_edge_r is registered alongside cnt_r so a clear and a hit arriving in the
  // same input cycle are seen together and the clear wins.
  always_comb begin
    state_nxt = state_r;
    move_nxt  = 1'b0;
    lrst_nxt  = 1'b0;
    prst_nxt  = 1'b0;
    dec_life  = 1'b0;
    case (state_r)
      S_IDLE: if (start) begin
        state_nxt = S_PLAY;
        lrst_nxt  = 1'b1;
        prst_nxt  = 1'b1;
      end
      S_PLAY: begin
        if (cnt_r == CNT_W'(N_ENEMIES)) begin
          if (level_r == LEVEL_W'(LEVELS - 1)) state_nxt = S_WON;
          else begin
            state_nxt = S_CLEAR;
            lrst_nxt  = 1'b1;
          end
        end else if (hit_edge_r) begin
          dec_life = 1'b1;
          if (lives_r == LIVES_W'(1)) state_nxt = S_LOST;
          else begin
            state_nxt = S_RESPAWN;
            prst_nxt  = 1'b1;
          end
        end else if (!start) begin
          state_nxt = S_PAUSE;
        end else if (frame_tick && fdiv_r == div_m1) begin
          move_nxt = 1'b1;
        end
      end
      S_PAUSE:   if (start) state_nxt = S_PLAY;
      S_RESPAWN: if (frame_tick && rsp_r == RSP_W'(RESPAWN_FRAMES - 1)) state_nxt = S_PLAY;
      S_CLEAR:   if (frame_tick) state_nxt = S_PLAY;
      S_WON, S_LOST: if (!start) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      move       <= 1'b0;
      level_rst  <= 1'b0;
      player_rst <= 1'b0;
      death      <= 1'b0;
      won        <= 1'b0;
      vblank_d1  <= 1'b0;
      hit_q      <= 1'b0;
      hit_edge_r <= 1'b0;
      cnt_r      <= '0;
      fdiv_r     <= '0;
      rsp_r      <= '0;
      bank_r     <= '0;
      score      <= '0;
      lives_r    <= LIVES_W'(LIVES);
      level_r    <= '0;
    end else begin
      state_r    <= state_nxt;
      move       <= move_nxt;
      level_rst  <= lrst_nxt;
      player_rst <= prst_nxt;
      death      <= (state_nxt == S_LOST);
      won        <= (state_nxt == S_WON);
      if (pixpulse) vblank_d1 <= vblank;
      hit_q      <= player_hit;
      hit_edge_r <= player_hit & ~hit_q;
      cnt_r      <= cnt_next;

      if (state_nxt != state_r || state_r != S_PLAY) fdiv_r <= '0;
      else if (frame_tick) fdiv_r <= (fdiv_r == div_m1) ? '0 : fdiv_r + DIV_W'(1);

      if (state_nxt != state_r || state_r != S_RESPAWN) rsp_r <= '0;
      else if (frame_tick) rsp_r <= rsp_r + RSP_W'(1);

      if (state_nxt == S_IDLE) begin
        bank_r  <= '0;
        score   <= '0;
        lives_r <= LIVES_W'(LIVES);
        level_r <= '0;
      end else begin
        if (dec_life) lives_r <= lives_r - LIVES_W'(1);
        if (state_r == S_PLAY && state_nxt == S_CLEAR) begin
          bank_r  <= bank_sat;
          level_r <= level_r + LEVEL_W'(1);
        end
        // score freezes in PAUSE, WON and LOST
        if (state_r inside {S_PLAY, S_RESPAWN, S_CLEAR}) score <= score_sat;
      end
    end
  end

  assign state = state_r;
  assign lives = lives_r;
  assign level = level_r;

endmodule
